// File: rtl/mam_mem_arbiter.sv
// mam_mem_arbiter: shares one MAM memory-access interface (request, write and
// read channels) between N_REQ requesters with transaction-granular
// round-robin arbitration. The grant is held from request acceptance through
// the last beat, so beats of different requesters never interleave.
// Optional: define MAM_ARB_STATS_EN to add stat_grants / stat_wait counters.
module mam_mem_arbiter #(
   parameter int N_REQ       = 2,
   parameter int DATA_WIDTH  = 512,
   parameter int ADDR_WIDTH  = 64,
   parameter int BEATS_WIDTH = 14
) (
   input  logic                            clk,
   input  logic                            rstn,
   // requester side
   input  logic [N_REQ-1:0]                s_req_valid,
   output logic [N_REQ-1:0]                s_req_ready,
   input  logic [N_REQ-1:0]                s_req_rw,
   input  logic [N_REQ*ADDR_WIDTH-1:0]     s_req_addr,
   input  logic [N_REQ-1:0]                s_req_burst,
   input  logic [N_REQ*BEATS_WIDTH-1:0]    s_req_beats,
   input  logic [N_REQ-1:0]                s_write_valid,
   output logic [N_REQ-1:0]                s_write_ready,
   input  logic [N_REQ*DATA_WIDTH-1:0]     s_write_data,
   input  logic [N_REQ*DATA_WIDTH/8-1:0]   s_write_strb,
   output logic [N_REQ-1:0]                s_read_valid,
   output logic [DATA_WIDTH-1:0]           s_read_data,
   input  logic [N_REQ-1:0]                s_read_ready,
   // memory side
   output logic                            req_valid,
   input  logic                            req_ready,
   output logic                            req_rw,
   output logic [ADDR_WIDTH-1:0]           req_addr,
   output logic                            req_burst,
   output logic [BEATS_WIDTH-1:0]          req_beats,
   output logic                            write_valid,
   input  logic                            write_ready,
   output logic [DATA_WIDTH-1:0]           write_data,
   output logic [DATA_WIDTH/8-1:0]         write_strb,
   input  logic                            read_valid,
   output logic                            read_ready,
   input  logic [DATA_WIDTH-1:0]           read_data,
   // status
   output logic [N_REQ-1:0]                grant,
   output logic                            busy
`ifdef MAM_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]             stat_grants,
   output logic [15:0]                     stat_wait
`endif
);

   localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, REQ, WRITE, READ} state_t;

   state_t                 state_q;
   logic [IDX_W-1:0]       owner_q;
   logic [IDX_W-1:0]       ptr_q;
   logic [BEATS_WIDTH-1:0] cnt_q;
   logic [N_REQ-1:0]       grant_q;
   logic                   busy_q;

   logic                   arb_found;
   logic [IDX_W-1:0]       arb_win;
   logic                   req_hs, wr_hs, rd_hs;
   logic [BEATS_WIDTH-1:0] cnt_d;

   // Requester index k steps after the pointer, wrapping modulo N_REQ.
   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr, input int k);
      int s;
      s = int'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return IDX_W'(s);
   endfunction

   // Round-robin search: first valid requester after the last-grant pointer.
   always_comb begin
      arb_found = 1'b0;
      arb_win   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!arb_found && s_req_valid[rr_idx(ptr_q, k)]) begin
            arb_found = 1'b1;
            arb_win   = rr_idx(ptr_q, k);
         end
      end
   end

   // Channel routing: data fields always follow the owner, valid/ready gated by state.
   always_comb begin
      req_valid     = 1'b0;
      req_rw        = s_req_rw[owner_q];
      req_addr      = s_req_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
      req_burst     = s_req_burst[owner_q];
      req_beats     = s_req_beats[int'(owner_q)*BEATS_WIDTH +: BEATS_WIDTH];
      write_valid   = 1'b0;
      write_data    = s_write_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
      write_strb    = s_write_strb[int'(owner_q)*STRB_W +: STRB_W];
      read_ready    = 1'b0;
      s_req_ready   = '0;
      s_write_ready = '0;
      s_read_valid  = '0;
      case (state_q)
         REQ: begin
            req_valid            = s_req_valid[owner_q];
            s_req_ready[owner_q] = req_ready;
         end
         WRITE: begin
            write_valid            = s_write_valid[owner_q];
            s_write_ready[owner_q] = write_ready;
         end
         READ: begin
            s_read_valid[owner_q] = read_valid;
            read_ready            = s_read_ready[owner_q];
         end
         default: ;
      endcase
   end

   assign s_read_data = read_data;

   assign req_hs = (state_q == REQ)   && s_req_valid[owner_q] && req_ready;
   assign wr_hs  = (state_q == WRITE) && write_valid && write_ready;
   assign rd_hs  = (state_q == READ)  && read_valid && read_ready;

   // Beat count to load on acceptance: single beat unless a non-zero burst.
   assign cnt_d = (req_burst && (req_beats != '0)) ? req_beats : BEATS_WIDTH'(1);

   // Arbitration FSM; grant and busy are registered alongside the state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= IDX_W'(N_REQ - 1);
         cnt_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_found) begin
                  owner_q <= arb_win;
                  grant_q <= N_REQ'(1) << arb_win;
                  busy_q  <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (req_hs) begin
                  cnt_q   <= cnt_d;
                  ptr_q   <= owner_q;
                  state_q <= req_rw ? WRITE : READ;
               end else if (!s_req_valid[owner_q]) begin
                  // owner withdrew: release without moving the pointer
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            WRITE: begin
               if (wr_hs) begin
                  cnt_q <= cnt_q - BEATS_WIDTH'(1);
                  if (cnt_q == BEATS_WIDTH'(1)) begin
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            READ: begin
               if (rd_hs) begin
                  cnt_q <= cnt_q - BEATS_WIDTH'(1);
                  if (cnt_q == BEATS_WIDTH'(1)) begin
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;

`ifdef MAM_ARB_STATS_EN
   logic [N_REQ-1:0][15:0] stat_grants_q;
   logic [15:0]            stat_wait_q;

   // Saturating per-requester grant counters and contention-cycle counter.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stat_grants_q <= '0;
         stat_wait_q   <= '0;
      end else begin
         if (req_hs && (stat_grants_q[owner_q] != 16'hFFFF))
            stat_grants_q[owner_q] <= stat_grants_q[owner_q] + 16'd1;
         if (busy_q && (|(s_req_valid & ~grant_q)) && (stat_wait_q != 16'hFFFF))
            stat_wait_q <= stat_wait_q + 16'd1;
      end
   end

   assign stat_grants = stat_grants_q;
   assign stat_wait   = stat_wait_q;
`endif

endmodule

// File: tb/tb_mam_mem_arbiter.sv
// Bench for mam_mem_arbiter: table of single-requester transactions plus
// hand-written multi-cycle sequences. Expected requests are queued when a
// requester is driven; expected beats are queued on request acceptance and
// compared when the beats pass through the arbiter.
module tb_mam_mem_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BW = 14;
   localparam int SW = DW / 8;

   logic              clk = 1'b0;
   logic              rstn;
   logic [N-1:0]      s_req_valid, s_req_ready, s_req_rw, s_req_burst;
   logic [N*AW-1:0]   s_req_addr;
   logic [N*BW-1:0]   s_req_beats;
   logic [N-1:0]      s_write_valid, s_write_ready;
   logic [N*DW-1:0]   s_write_data;
   logic [N*SW-1:0]   s_write_strb;
   logic [N-1:0]      s_read_valid, s_read_ready;
   logic [DW-1:0]     s_read_data;
   logic              req_valid, req_ready, req_rw, req_burst;
   logic [AW-1:0]     req_addr;
   logic [BW-1:0]     req_beats;
   logic              write_valid, write_ready;
   logic [DW-1:0]     write_data;
   logic [SW-1:0]     write_strb;
   logic              read_valid, read_ready;
   logic [DW-1:0]     read_data;
   logic [N-1:0]      grant;
   logic              busy;
`ifdef MAM_ARB_STATS_EN
   logic [N*16-1:0]   stat_grants;
   logic [15:0]       stat_wait;
`endif

   mam_mem_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEATS_WIDTH(BW)) dut (
      .clk(clk), .rstn(rstn),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_rw(s_req_rw),
      .s_req_addr(s_req_addr), .s_req_burst(s_req_burst), .s_req_beats(s_req_beats),
      .s_write_valid(s_write_valid), .s_write_ready(s_write_ready),
      .s_write_data(s_write_data), .s_write_strb(s_write_strb),
      .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ready(s_read_ready),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
      .req_burst(req_burst), .req_beats(req_beats),
      .write_valid(write_valid), .write_ready(write_ready),
      .write_data(write_data), .write_strb(write_strb),
      .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
      .grant(grant), .busy(busy)
`ifdef MAM_ARB_STATS_EN
      , .stat_grants(stat_grants), .stat_wait(stat_wait)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int           id;
      logic [AW-1:0] addr;
      logic         rw;
      logic         burst;
      logic [BW-1:0] beats;
   } req_exp_t;

   typedef struct {
      int            id;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
   } beat_exp_t;

   typedef struct {
      int            id;
      logic          rw;
      logic          burst;
      logic [BW-1:0] beats;
      logic [AW-1:0] addr;
      int            exp_nb;   // expected number of data beats
   } vec_t;

   req_exp_t  exp_req[$];
   beat_exp_t exp_wr[$];
   beat_exp_t exp_rd[$];

   logic [N-1:0] pend;
   logic [N-1:0] req_hs_f, wr_hs_f;
   logic         rd_hs_f;
   int           nb_of[N];
   int           wbeat[N];
   int           rd_cnt, cyc_cnt;
   logic         mem_req_rdy, mem_stall;
   int           checks, errors;

   function automatic logic [DW-1:0] wdata(input int i, input int b);
      return 32'hA000_0000 | DW'(i << 16) | DW'(b & 16'hFFFF);
   endfunction

   function automatic logic [SW-1:0] wstrb(input int i, input int b);
      return SW'((b * 3 + i + 1) & 15);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event, expected none", name);
   endtask

   // Requester and memory-side models drive from their current state.
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         s_req_valid[i]            = pend[i];
         s_write_data[i*DW +: DW]  = wdata(i, wbeat[i]);
         s_write_strb[i*SW +: SW]  = wstrb(i, wbeat[i]);
      end
      s_write_valid = '1;
      s_read_ready  = '1;
      req_ready     = mem_req_rdy;
      write_ready   = !mem_stall || (cyc_cnt % 3 != 2);
      read_valid    = !mem_stall || (cyc_cnt % 4 != 3);
      read_data     = 32'hD000_0000 + DW'(rd_cnt);
   endtask

   // Negedge monitor: per-cycle invariants plus scoreboard on every handshake.
   task automatic mon();
      req_exp_t  e;
      beat_exp_t b;
      @(negedge clk);
      req_hs_f = '0;
      wr_hs_f  = '0;
      rd_hs_f  = 1'b0;
      if (rstn) begin
         chk("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
         chk("req_ready_owner_only", 64'(s_req_ready & ~grant), 64'd0);
         chk("write_ready_owner_only", 64'(s_write_ready & ~grant), 64'd0);
         chk("read_valid_owner_only", 64'(s_read_valid & ~grant), 64'd0);
         for (int i = 0; i < N; i++) begin
            req_hs_f[i] = s_req_valid[i] && s_req_ready[i];
            wr_hs_f[i]  = s_write_valid[i] && s_write_ready[i];
         end
         if (req_valid && req_ready) begin
            if (exp_req.size() == 0) fail_now("unexpected_request");
            else begin
               e = exp_req.pop_front();
               chk("req_grant", 64'(grant), 64'(1) << e.id);
               chk("req_addr", 64'(req_addr), 64'(e.addr));
               chk("req_rw", 64'(req_rw), 64'(e.rw));
               chk("req_burst", 64'(req_burst), 64'(e.burst));
               chk("req_beats", 64'(req_beats), 64'(e.beats));
               for (int k = 0; k < nb_of[e.id]; k++) begin
                  if (e.rw) exp_wr.push_back('{e.id, wdata(e.id, wbeat[e.id] + k), wstrb(e.id, wbeat[e.id] + k)});
                  else      exp_rd.push_back('{e.id, 32'hD000_0000 + DW'(rd_cnt + k), '0});
               end
            end
         end
         if (write_valid && write_ready) begin
            if (exp_wr.size() == 0) fail_now("unexpected_write_beat");
            else begin
               b = exp_wr.pop_front();
               chk("wr_grant", 64'(grant), 64'(1) << b.id);
               chk("wr_data", 64'(write_data), 64'(b.data));
               chk("wr_strb", 64'(write_strb), 64'(b.strb));
            end
         end
         if (read_valid && read_ready) begin
            rd_hs_f = 1'b1;
            if (exp_rd.size() == 0) fail_now("unexpected_read_beat");
            else begin
               b = exp_rd.pop_front();
               chk("rd_route", 64'(s_read_valid), 64'(1) << b.id);
               chk("rd_data", 64'(s_read_data), 64'(b.data));
            end
         end
      end
   endtask

   // Just after the posedge: advance models by the handshakes seen.
   task automatic upd();
      @(posedge clk);
      #1;
      cyc_cnt++;
      for (int i = 0; i < N; i++) begin
         if (req_hs_f[i]) pend[i] = 1'b0;
         if (wr_hs_f[i])  wbeat[i]++;
      end
      if (rd_hs_f) rd_cnt++;
      drive();
   endtask

   task automatic issue(input int id, input logic rw, input logic burst, input logic [BW-1:0] beats,
                        input logic [AW-1:0] addr, input int nb, input bit push);
      s_req_rw[id]                 = rw;
      s_req_burst[id]              = burst;
      s_req_beats[id*BW +: BW]     = beats;
      s_req_addr[id*AW +: AW]      = addr;
      nb_of[id]                    = nb;
      pend[id]                     = 1'b1;
      s_req_valid[id]              = 1'b1;
      if (push) exp_req.push_back('{id, addr, rw, burst, beats});
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((exp_req.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 || busy || (|pend))
             && n < budget) begin
         mon();
         upd();
         n++;
      end
      chk({name, "_completes"}, 64'(n < budget), 64'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant"}, 64'(grant), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
      chk({tag, "_write_valid"}, 64'(write_valid), 64'd0);
      chk({tag, "_read_ready"}, 64'(read_ready), 64'd0);
      chk({tag, "_s_req_ready"}, 64'(s_req_ready), 64'd0);
      chk({tag, "_s_write_ready"}, 64'(s_write_ready), 64'd0);
      chk({tag, "_s_read_valid"}, 64'(s_read_valid), 64'd0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      pend = '0;
      exp_req.delete();
      exp_wr.delete();
      exp_rd.delete();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   vec_t tbl[6];

   initial begin
      int n;
      int w0;
      checks = 0; errors = 0;
      rd_cnt = 0; cyc_cnt = 0;
      pend = '0; req_hs_f = '0; wr_hs_f = '0; rd_hs_f = 1'b0;
      for (int i = 0; i < N; i++) begin nb_of[i] = 1; wbeat[i] = 0; end
      s_req_rw = '0; s_req_burst = '0; s_req_addr = '0; s_req_beats = '0;
      mem_req_rdy = 1'b1; mem_stall = 1'b1;
      rstn = 1'b0;
      drive();

      //           id rw burst beats addr            nb
      tbl[0] = '{0, 1'b0, 1'b0, 14'd5, 32'h0000_1100, 1};  // burst=0 ignores beats
      tbl[1] = '{1, 1'b1, 1'b1, 14'd4, 32'h0000_2000, 4};
      tbl[2] = '{0, 1'b1, 1'b1, 14'd0, 32'h0000_2400, 1};  // beats=0 -> one beat
      tbl[3] = '{1, 1'b0, 1'b1, 14'd3, 32'h0000_2800, 3};
      tbl[4] = '{0, 1'b0, 1'b1, 14'd2, 32'h0000_2C00, 2};
      tbl[5] = '{1, 1'b1, 1'b0, 14'd9, 32'h0000_3000, 1};

      // reset state, then a single read with one-cycle request latency
      do_reset();
      mon(); chk_idle("reset");
`ifdef MAM_ARB_STATS_EN
      chk("reset_stat_grants", 64'(stat_grants), 64'd0);
      chk("reset_stat_wait", 64'(stat_wait), 64'd0);
`endif
      upd();
      issue(0, 1'b0, 1'b0, 14'd5, 32'h0000_1000, 1, 1'b1);
      mon(); chk("lat_c0_req_valid", 64'(req_valid), 64'd0);
      upd();
      mon(); chk("lat_c1_req_valid", 64'(req_valid), 64'd1);
      chk("lat_c1_grant", 64'(grant), 64'd1);
      chk("lat_c1_busy", 64'(busy), 64'd1);
      upd();
      wait_done("single_read", 50);
      mon(); chk_idle("after_read"); upd();

      // table of single-requester transactions
      for (int v = 0; v < 6; v++) begin
         issue(tbl[v].id, tbl[v].rw, tbl[v].burst, tbl[v].beats, tbl[v].addr, tbl[v].exp_nb, 1'b1);
         wait_done("table", 200);
         mon(); chk_idle("table_end"); upd();
      end

      // both requesting from reset: grant order 0,1,0,1,0,1
      do_reset();
      mem_stall = 1'b0;
      upd();
      for (int r = 0; r < 3; r++) begin
         issue(0, 1'b0, 1'b0, 14'd1, 32'h0000_4000 + AW'(r), 1, 1'b1);
         issue(1, 1'b0, 1'b0, 14'd1, 32'h0000_5000 + AW'(r), 1, 1'b1);
         wait_done("round_robin", 100);
      end
`ifdef MAM_ARB_STATS_EN
      chk("rr_stat_grants", 64'(stat_grants), 64'h0003_0003);
      chk("rr_stat_wait", 64'(stat_wait), 64'd6);
`endif

      // write burst of 4 from requester 1 while requester 0 waits
      do_reset();
      mem_stall = 1'b1;
      upd();
      w0 = wbeat[1];
      issue(1, 1'b1, 1'b1, 14'd4, 32'h0000_6000, 4, 1'b1);
      n = 0;
      while (grant != 2'b10 && n < 20) begin mon(); upd(); n++; end
      chk("wr_burst_granted", 64'(n < 20), 64'd1);
      issue(0, 1'b0, 1'b0, 14'd1, 32'h0000_6400, 1, 1'b1);
      wait_done("write_burst", 200);
      chk("wr_burst_beat_count", 64'(wbeat[1] - w0), 64'd4);

      // owner withdraws in REQ: back to IDLE, pointer unchanged
      do_reset();
      mem_req_rdy = 1'b0;
      upd();
      issue(0, 1'b0, 1'b0, 14'd1, 32'h0000_7000, 1, 1'b0);
      mon(); upd();
      mon(); chk("drop_req_grant", 64'(grant), 64'd1);
      chk("drop_req_valid", 64'(req_valid), 64'd1);
      upd();
      pend[0] = 1'b0; s_req_valid[0] = 1'b0;
      mon(); chk("drop_req_valid_low", 64'(req_valid), 64'd0);
      upd();
      mon(); chk("drop_idle_grant", 64'(grant), 64'd0);
      chk("drop_idle_busy", 64'(busy), 64'd0);
      mem_req_rdy = 1'b1;
      upd();
      issue(0, 1'b0, 1'b0, 14'd1, 32'h0000_7000, 1, 1'b1);
      issue(1, 1'b0, 1'b0, 14'd1, 32'h0000_7100, 1, 1'b1);
      wait_done("drop_regrant", 100);

      // reset during the 2nd beat of a 4-beat read
      do_reset();
      mem_stall = 1'b0;
      upd();
      issue(0, 1'b0, 1'b1, 14'd4, 32'h0000_8000, 4, 1'b1);
      n = 0;
      while (!(exp_req.size() == 0 && exp_rd.size() == 3) && n < 30) begin mon(); upd(); n++; end
      chk("midrst_first_beat", 64'(n < 30), 64'd1);
      rstn = 1'b0;
      exp_rd.delete();
      mon(); upd();
      rstn = 1'b1;
      mon();
      chk("midrst_grant", 64'(grant), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_read_ready", 64'(read_ready), 64'd0);
      chk("midrst_s_read_valid", 64'(s_read_valid), 64'd0);
`ifdef MAM_ARB_STATS_EN
      chk("midrst_stat_grants", 64'(stat_grants), 64'd0);
`endif
      upd();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
